// File: rtl/mips_pkg.sv
// Shared types and defaults for the MEM-stage data-memory access block.
package mips_pkg;

    localparam int unsigned XLEN = 32;

    localparam int unsigned    TIMEOUT_CYCLES_DEF = 16;
    localparam logic [XLEN-1:0] ERR_DATA_DEF      = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    // Request payload held stable on the data-memory bus for the whole access.
    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } dmem_cmd_t;

    // Force a byte address onto a word boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Wait-cycle counter for an outstanding data-memory request.
module mem_timeout_ctr #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

    logic [CNT_W-1:0] cnt;

    // Count un-acked wait cycles; hold once the limit is reached.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = (cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_access.sv
// MEM-stage data-memory access controller: stalls the pipeline while a
// word access is outstanding, aborts on timeout, flags misaligned accesses.
module mem_access
    import mips_pkg::*;
#(
    parameter int unsigned    TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter logic [XLEN-1:0] ERR_DATA      = ERR_DATA_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ctrl_memRead_ex_mem,
    input  logic            ctrl_memWrite_ex_mem,
    input  logic [XLEN-1:0] alu_result_ex_mem,
    input  logic [XLEN-1:0] write_data_ex_mem,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_ack,
    output logic [XLEN-1:0] read_data_from_mem,
    output logic            mem_stall,
    output logic            misaligned_fault,
    output logic            bus_timeout
);

    mem_state_e      state, state_next;
    dmem_cmd_t       cmd_q;
    logic            capture;
    logic            load_rd;
    logic [XLEN-1:0] rd_next;
    logic            ctr_clear;
    logic            ctr_en;
    logic            expired;
    logic            access;
    logic            aligned;

    assign access  = ctrl_memRead_ex_mem | ctrl_memWrite_ex_mem;
    assign aligned = (alu_result_ex_mem[1:0] == 2'b00);

    mem_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk     (clk),
        .reset   (reset),
        .clear   (ctr_clear),
        .enable  (ctr_en),
        .expired (expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode; pulses and stall are forced low in reset.
    always_comb begin
        state_next       = state;
        dmem_req         = 1'b0;
        mem_stall        = 1'b0;
        misaligned_fault = 1'b0;
        bus_timeout      = 1'b0;
        capture          = 1'b0;
        load_rd          = 1'b0;
        rd_next          = dmem_rdata;
        ctr_clear        = 1'b0;
        ctr_en           = 1'b0;
        case (state)
            ST_IDLE: begin
                if (access) begin
                    if (aligned) begin
                        mem_stall  = 1'b1;
                        capture    = 1'b1;
                        ctr_clear  = 1'b1;
                        state_next = ST_BUSY;
                    end else begin
                        misaligned_fault = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                dmem_req  = 1'b1;
                mem_stall = 1'b1;
                if (dmem_ack) begin
                    load_rd    = !cmd_q.we;
                    state_next = ST_DONE;
                end else if (expired) begin
                    bus_timeout = 1'b1;
                    load_rd     = !cmd_q.we;
                    rd_next     = ERR_DATA;
                    state_next  = ST_DONE;
                end else begin
                    ctr_en = 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (!reset) begin
            mem_stall        = 1'b0;
            misaligned_fault = 1'b0;
            bus_timeout      = 1'b0;
        end
    end

    // Latch the bus command on IDLE->BUSY and the load result on completion.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cmd_q              <= '0;
            read_data_from_mem <= '0;
        end else begin
            if (capture) begin
                cmd_q.we    <= ctrl_memWrite_ex_mem;
                cmd_q.addr  <= word_align(alu_result_ex_mem);
                cmd_q.wdata <= write_data_ex_mem;
            end
            if (load_rd) begin
                read_data_from_mem <= rd_next;
            end
        end
    end

    assign dmem_we    = cmd_q.we;
    assign dmem_addr  = cmd_q.addr;
    assign dmem_wdata = cmd_q.wdata;

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: max BUSY cycles waiting for dmem_ack before abort.
REQ-002 Parameter ERR_DATA, default 32'h0000_0000: value loaded into read_data_from_mem on timeout.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 ctrl_memRead_ex_mem  input  1  load in MEM stage.
REQ-006 ctrl_memWrite_ex_mem  input  1  store in MEM stage.
REQ-007 alu_result_ex_mem  input  32  byte address of the access.
REQ-008 write_data_ex_mem  input  32  store data.
REQ-009 dmem_req  output  1  data-memory request.
REQ-010 dmem_we  output  1  1 = write, 0 = read.
REQ-011 dmem_addr  output  32  word-aligned address.
REQ-012 dmem_wdata  output  32  store data to memory.
REQ-013 dmem_rdata  input  32  load data, valid with dmem_ack.
REQ-014 dmem_ack  input  1  one-cycle completion strobe.
REQ-015 read_data_from_mem  output  32  registered load result to the MEM/WB register.
REQ-016 mem_stall  output  1  freezes PC, IF/ID, ID/EX, EX/MEM while high.
REQ-017 misaligned_fault  output  1  one-cycle pulse: access with addr[1:0] != 0.
REQ-018 bus_timeout  output  1  one-cycle pulse: access aborted by timeout.

Function
REQ-019 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-020 In IDLE, an access (read or write) with addr[1:0]==0 SHALL assert mem_stall combinationally in the same cycle and move to BUSY at the next edge.
REQ-021 When both read and write are asserted, the write SHALL win and dmem_we=1.
REQ-022 In BUSY, dmem_req SHALL be 1 and dmem_we, dmem_addr and dmem_wdata SHALL be registered values captured on IDLE->BUSY, held stable until exit.
REQ-023 In BUSY with dmem_ack=1, a read SHALL load dmem_rdata into read_data_from_mem, a write SHALL leave it unchanged, and the FSM SHALL go to DONE.
REQ-024 In DONE, mem_stall SHALL be 0 and dmem_req 0 for exactly one cycle, so the pipeline advances; DONE SHALL always go to IDLE.
REQ-025 Minimum access latency SHALL be 3 cycles (IDLE detect, BUSY with ack, DONE); each wait cycle without ack adds one.
REQ-026 A BUSY wait counter SHALL clear on entry to BUSY and increment each BUSY cycle without ack.
REQ-027 When the counter reaches TIMEOUT_CYCLES-1 without ack, the block SHALL pulse bus_timeout, go to DONE, and load ERR_DATA for reads.
REQ-028 An ack in the same cycle as timeout expiry SHALL win, with no bus_timeout pulse.
REQ-029 In IDLE, a misaligned access SHALL pulse misaligned_fault for one cycle, issue no request, leave mem_stall low and keep read_data_from_mem unchanged.
REQ-030 dmem_ack outside BUSY SHALL be ignored.
REQ-031 mem_stall SHALL be 1 in BUSY, and in IDLE only under REQ-020; otherwise 0.

Reset
REQ-032 With reset low at a rising edge, the FSM SHALL go to IDLE, the counter to 0, read_data_from_mem to 0, and the registered dmem_* values to 0.
REQ-033 Reset mid-BUSY SHALL drop dmem_req from the next cycle, with no timeout or fault pulse; a late ack SHALL be ignored.
REQ-034 While reset is low, mem_stall, misaligned_fault and bus_timeout SHALL be 0.

Structure
REQ-035 The state enum and the default values of TIMEOUT_CYCLES and ERR_DATA SHALL live in shared package mips_pkg.
REQ-036 The wait counter SHALL be a sub-module mem_timeout_ctr (clear, enable, expired output).

Verification
REQ-037 Load from 0x0000_0010, ack in first BUSY cycle with rdata 0xCAFE_F00D -> stall high 2 cycles, read_data_from_mem=0xCAFE_F00D in DONE, dmem_we=0.
REQ-038 Store 0x1234_5678 to 0x0000_0020, ack after 3 wait cycles -> dmem_we=1, addr/wdata stable for all 4 BUSY cycles, stall high 5 cycles, read data unchanged.
REQ-039 Load from 0x0000_0013 -> misaligned_fault pulses 1 cycle, dmem_req never asserts, mem_stall stays 0.
REQ-040 Load, no ack, TIMEOUT_CYCLES=16 -> bus_timeout pulses in 16th BUSY cycle, read_data_from_mem=ERR_DATA, then DONE then IDLE.
REQ-041 Reset low in 2nd BUSY cycle, ack the next cycle -> dmem_req=0 after that edge, FSM IDLE, read_data_from_mem=0, ack ignored.
REQ-042 Read and write both high at 0x0000_0040 -> single request with dmem_we=1.
